mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the Y86-64 SEQ datapath. It sits between execute (valE) and write-back/PC update (valM).
- Owns the byte-wide data memory.
- Decodes which icodes read or write memory and selects the address and write data.
- Performs each 8-byte little-endian access as 8 single-byte cycles under a start/done handshake.
- Flags out-of-range addresses so the top level can raise stat = ADR.

Parameters:
MEM_BYTES, 1024, data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
ADDR_W, 64, width of valE/valA/valP used as addresses.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
icode  input  4  instruction code of the current instruction.
valE  input  64  ALU result from execute.
valA  input  64  register value A from decode.
valP  input  64  incremented PC from fetch.
busy  output  1  high while an access is in progress (XFER state).
done  output  1  one-cycle completion pulse.
valM  output  64  last completed read data.
mem_err  output  1  address fault on the last accepted request.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; busy=0, done=0, valM=0, mem_err=0; byte index=0.
  - Memory array is NOT cleared by reset.
  - Reset mid-transfer aborts the access. Bytes already written stay written. valM is cleared to 0.
  - Reset has priority over start.

- Op selection per icode, latched at start:
  - rmmovq (4): write valA at valE.
  - mrmovq (5): read at valE.
  - call (8): write valP at valE.
  - pushq (A): write valA at valE.
  - ret (9): read at valA.
  - popq (B): read at valA.
  - All other icodes: no access.

- Address check at start: fault if addr > MEM_BYTES-8.
  - Compare as unsigned 64-bit, so a 64-bit wrap of addr+7 is also a fault.
  - On fault: no memory byte is touched and valM is unchanged.

- FSM states: IDLE, XFER, DONE.
  - IDLE, start=1, memory op, address ok: latch op/addr/data; clear shadow read register; idx=0; go to XFER.
  - IDLE, start=1, non-memory op or faulting address: go to DONE directly.
    - mem_err <= 1 for a fault; mem_err <= 0 for a non-memory op.
  - IDLE, start=1, memory op with valid address: mem_err <= 0.
  - XFER, each edge:
    - Write: mem[addr+idx] <= data[8*idx+7:8*idx].
    - Read: shadow[8*idx+7:8*idx] <= mem[addr+idx].
    - idx increments; after idx==7 go to DONE.
  - DONE: done=1 for exactly this cycle.
    - If the op was a read, valM <= shadow on the edge leaving DONE. valM must also be visible during DONE: implement by loading valM on the idx==7 edge.
    - Next state is IDLE.

- Latency, with start high in cycle N:
  - Memory op: busy high in cycles N+1..N+8; done high in cycle N+9.
  - No-op or fault: done high in cycle N+1; busy stays 0.

- Handshake and output rules:
  - start while in XFER or DONE is ignored. No queueing.
  - start may be held high: it is re-sampled in IDLE, so each IDLE cycle with start=1 begins a new request.
  - busy and done are never high together.
  - valM holds its value across writes, no-ops and faults.
  - mem_err holds until the next accepted start.
  - Byte order is little-endian: byte idx 0 is the LSB, at the lowest address.
  - The top-level sequencer must hold the PC/register update until done.

Decomposition:
- Shared package y86_pkg: icode constants I_HALT=0 through I_POPQ=B, stat codes (AOK/HLT/ADR/INS), mem_stage FSM state enum.
- One natural sub-module, data_ram: byte-wide single-port synchronous-write RAM, MEM_BYTES deep, with a combinational read.
  - The FSM, address check and op decode stay in mem_stage.

Test Plan:
- Write: rmmovq, valE=0x10, valA=0x1122334455667788, start in cycle N → busy N+1..N+8, done N+9, mem_err=0.
- Read-back: mrmovq at valE=0x10 → done at N+9, valM=0x1122334455667788; mem[0x10]=0x88 and mem[0x17]=0x11.
- Stack ops:
  - pushq, valE=0x3F8, valA=0xDEAD → mem[0x3F8..0x3FF] written.
  - Then popq with valA=0x3F8 → valM=0xDEAD.
  - call, valE=0x3F0, valP=0x40 → ret with valA=0x3F0 gives valM=0x40.
- Faults:
  - mrmovq, valE=MEM_BYTES-7 (0x3F9) → done at N+1, mem_err=1, valM unchanged, busy never high.
  - valE=0xFFFFFFFFFFFFFFFC → mem_err=1.
  - valE=0x3F8 → mem_err=0.
- Non-memory and protocol: icode=6 (OPq) → done at N+1, mem_err=0, no memory change.
  - Extra start pulses during XFER are ignored: exactly one done per accepted start.
- Reset mid-op: rmmovq at 0x20 with valA=0xFFFFFFFFFFFFFFFF over 0-filled memory; assert reset in cycle N+4.
  - Required: state IDLE, busy=0, valM=0.
  - Only bytes 0x20..0x22 or 0x20..0x23 hold 0xFF, depending on reset edge alignment (bench checks against its model).
  - A subsequent start is served normally.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions used by the SEQ datapath stages.
// Contents: instruction codes, status codes, the memory-stage FSM state
// enum and a byte-lane helper for little-endian 64-bit words.
package y86_pkg;

    // Instruction codes (icode field of the first instruction byte)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Processor status codes
    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Memory-stage sequencer states
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_XFER = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

    // Extract byte lane idx (0 = least significant) from a 64-bit word.
    function automatic logic [7:0] get_byte(input logic [63:0] word, input logic [2:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-wide single-port data memory.
// Write is synchronous (rising edge, when we=1); read is combinational
// from the same address. Contents are deliberately not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - byte address
//   wdata - byte to write
//   rdata - byte currently stored at addr
module data_ram #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_BYTES];

    // Synchronous byte write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the Y86-64 SEQ datapath.
// Decodes whether the current instruction reads or writes memory, checks
// the address range, then moves the 8-byte little-endian operand one byte
// per cycle through data_ram under a start/done handshake.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start              - request pulse, only honoured while idle
//   icode              - instruction code of the current instruction
//   valE, valA, valP   - execute result, register A, incremented PC
//   busy               - high while bytes are being transferred
//   done               - one-cycle completion pulse
//   valM               - data of the last completed read
//   mem_err            - address fault on the last accepted request
module mem_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valE,
    input  logic [ADDR_W-1:0] valA,
    input  logic [ADDR_W-1:0] valP,
    output logic              busy,
    output logic              done,
    output logic [63:0]       valM,
    output logic              mem_err
);

    localparam int AW = $clog2(MEM_BYTES);

    ms_state_t         state_r, state_next_s;
    logic [2:0]        idx_r;
    logic [AW-1:0]     addr_r;
    logic [63:0]       wdata_r;
    logic              is_write_r;
    logic [63:0]       shadow_r;
    logic [63:0]       valm_r;
    logic              err_r;
    logic              busy_r;
    logic              done_r;

    logic              is_read_s;
    logic              is_write_s;
    logic              mem_op_s;
    logic              fault_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic [ADDR_W-1:0] wdata_sel_s;
    logic [63:0]       shadow_next_s;
    logic              ram_we_s;
    logic [AW-1:0]     ram_addr_s;
    logic [7:0]        ram_wdata_s;
    logic [7:0]        ram_rdata_s;

    // Decode access type, address source and write-data source from icode
    always_comb begin
        is_read_s   = 1'b0;
        is_write_s  = 1'b0;
        addr_sel_s  = valE;
        wdata_sel_s = valA;
        case (icode)
            I_RMMOVQ: is_write_s = 1'b1;
            I_MRMOVQ: is_read_s  = 1'b1;
            I_CALL: begin
                is_write_s  = 1'b1;
                wdata_sel_s = valP;
            end
            I_PUSHQ:  is_write_s = 1'b1;
            I_RET: begin
                is_read_s  = 1'b1;
                addr_sel_s = valA;
            end
            I_POPQ: begin
                is_read_s  = 1'b1;
                addr_sel_s = valA;
            end
            default: begin
                is_read_s  = 1'b0;
                is_write_s = 1'b0;
            end
        endcase
    end

    assign mem_op_s = is_read_s | is_write_s;
    // Unsigned full-width compare: addresses whose last byte would land past
    // the array (including 64-bit wrap of addr+7) are rejected up front.
    assign fault_s  = (addr_sel_s > ADDR_W'(MEM_BYTES - 8));

    // RAM port: addr_r+idx cannot overflow because the range check passed
    assign ram_addr_s  = addr_r + AW'(idx_r);
    assign ram_wdata_s = get_byte(wdata_r, idx_r);
    // Suppress the write on a reset edge so a reset aborts the byte in flight
    assign ram_we_s    = (state_r == MS_XFER) && is_write_r && !reset;

    // Merge the byte read this cycle into the shadow read register
    always_comb begin
        shadow_next_s = shadow_r;
        shadow_next_s[{idx_r, 3'b000} +: 8] = ram_rdata_s;
    end

    // Next-state logic of the transfer sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MS_IDLE: begin
                if (start) begin
                    if (mem_op_s && !fault_s) begin
                        state_next_s = MS_XFER;
                    end else begin
                        state_next_s = MS_DONE;
                    end
                end else begin
                    state_next_s = MS_IDLE;
                end
            end
            MS_XFER: begin
                if (idx_r == 3'd7) begin
                    state_next_s = MS_DONE;
                end else begin
                    state_next_s = MS_XFER;
                end
            end
            MS_DONE: state_next_s = MS_IDLE;
            default: state_next_s = MS_IDLE;
        endcase
    end

    // State register, request latching, byte counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= MS_IDLE;
            idx_r      <= 3'd0;
            addr_r     <= '0;
            wdata_r    <= 64'd0;
            is_write_r <= 1'b0;
            shadow_r   <= 64'd0;
            valm_r     <= 64'd0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == MS_XFER);
            done_r  <= (state_next_s == MS_DONE);
            case (state_r)
                MS_IDLE: begin
                    if (start) begin
                        err_r <= mem_op_s && fault_s;
                        if (mem_op_s && !fault_s) begin
                            addr_r     <= addr_sel_s[AW-1:0];
                            wdata_r    <= wdata_sel_s;
                            is_write_r <= is_write_s;
                            shadow_r   <= 64'd0;
                            idx_r      <= 3'd0;
                        end
                    end
                end
                MS_XFER: begin
                    idx_r <= idx_r + 3'd1;
                    if (!is_write_r) begin
                        shadow_r <= shadow_next_s;
                        // Publish on the last byte so valM is already valid while done is high
                        if (idx_r == 3'd7) begin
                            valm_r <= shadow_next_s;
                        end
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign valM    = valm_r;
    assign mem_err = err_r;

    data_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a transaction-level reference model
// (byte array plus an "elapsed bytes" counter per accepted request) runs
// beside the DUT; a compare process checks every output every cycle, and
// directed sequences pin the model with hand-computed literals.
module tb_mem_stage;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valE = 64'd0;
    logic [63:0] valA = 64'd0;
    logic [63:0] valP = 64'd0;
    logic        busy, done, mem_err;
    logic [63:0] valM;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    mem_stage #(.MEM_BYTES(MEM), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .busy(busy), .done(done), .valM(valM), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [7:0]  mmem [MEM];
    bit        m_act = 1'b0;
    int        m_t = 0;
    bit        m_wr = 1'b0;
    int        m_addr = 0;
    bit [63:0] m_data = 64'd0;
    bit        e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    bit [63:0] e_valM = 64'd0;

    task automatic model_step();
        int op;
        bit [63:0] a;
        bit [63:0] d;
        if (reset) begin
            m_act = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_valM = 64'd0;
        end else if (m_act) begin
            if (m_wr) mmem[m_addr + m_t] = m_data[8*m_t +: 8];
            m_t++;
            if (m_t == 8) begin
                m_act = 1'b0; e_busy = 1'b0; e_done = 1'b1;
                if (!m_wr) begin
                    for (int i = 0; i < 8; i++) e_valM[8*i +: 8] = mmem[m_addr + i];
                end
            end
        end else if (e_done) begin
            e_done = 1'b0;
        end else if (start) begin
            op = 0; a = valE; d = valA;
            case (icode)
                4'h4: op = 2;
                4'h5: op = 1;
                4'h8: begin op = 2; d = valP; end
                4'h9: begin op = 1; a = valA; end
                4'hA: op = 2;
                4'hB: begin op = 1; a = valA; end
                default: op = 0;
            endcase
            if (op == 0) begin
                e_err = 1'b0; e_done = 1'b1;
            end else if (a > 64'(MEM - 8)) begin
                e_err = 1'b1; e_done = 1'b1;
            end else begin
                e_err = 1'b0; e_busy = 1'b1; m_act = 1'b1; m_t = 0;
                m_wr = (op == 2); m_addr = int'(a); m_data = d;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", {63'd0, busy}, {63'd0, e_busy});
                check("done", {63'd0, done}, {63'd0, e_done});
                check("mem_err", {63'd0, mem_err}, {63'd0, e_err});
                check("valM", valM, e_valM);
                check("busy_and_done", {63'd0, busy & done}, 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Issue one request, return cycles from start to done (-1 on timeout)
    task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, output int lat);
        @(negedge clk);
        start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 64'($urandom_range(0, MEM - 8));
        else if (r == 7) return 64'($urandom_range(MEM - 7, MEM - 1));
        else if (r == 8) return rand64() | 64'h0000_0100_0000_0000;
        else             return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int ndone;
        int bad;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_valM", valM, 64'd0);
        check("reset_err", {63'd0, mem_err}, 64'd0);
        reset = 1'b0;

        // Zero-fill the whole memory so every later read has a known value
        for (int i = 0; i < MEM / 8; i++) run_op(4'h4, 64'(i * 8), 64'd0, 64'd0, lat);

        run_op(4'h4, 64'h10, 64'h1122334455667788, 64'd0, lat);
        check("wr_latency", 64'(lat), 64'd9);
        check("wr_err", {63'd0, mem_err}, 64'd0);
        run_op(4'h5, 64'h10, 64'd0, 64'd0, lat);
        check("rd_latency", 64'(lat), 64'd9);
        check("rd_valM", valM, 64'h1122334455667788);
        check("mem_0x10", 64'(dut.u_ram.mem[16]), 64'h88);
        check("mem_0x17", 64'(dut.u_ram.mem[23]), 64'h11);

        run_op(4'hA, 64'h3F8, 64'hDEAD, 64'd0, lat);
        run_op(4'hB, 64'd0, 64'h3F8, 64'd0, lat);
        check("pop_valM", valM, 64'hDEAD);
        run_op(4'h8, 64'h3F0, 64'd0, 64'h40, lat);
        run_op(4'h9, 64'd0, 64'h3F0, 64'd0, lat);
        check("ret_valM", valM, 64'h40);

        run_op(4'h5, 64'h3F9, 64'd0, 64'd0, lat);
        check("fault_latency", 64'(lat), 64'd1);
        check("fault_err", {63'd0, mem_err}, 64'd1);
        check("fault_valM_held", valM, 64'h40);
        run_op(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, lat);
        check("wrap_err", {63'd0, mem_err}, 64'd1);
        run_op(4'h5, 64'h3F8, 64'd0, 64'd0, lat);
        check("edge_ok_err", {63'd0, mem_err}, 64'd0);
        check("edge_ok_valM", valM, 64'hDEAD);

        run_op(4'h6, 64'h3F9, 64'd0, 64'd0, lat);
        check("nop_latency", 64'(lat), 64'd1);
        check("nop_err", {63'd0, mem_err}, 64'd0);

        // Extra start pulses during the transfer must be ignored
        @(negedge clk);
        start = 1'b1; icode = 4'h4; valE = 64'h100; valA = rand64();
        ndone = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = (k >= 1 && k <= 4);
            icode = (k % 2 == 0) ? 4'h6 : 4'h5;
            if (done) ndone++;
        end
        start = 1'b0;
        check("one_done_per_start", 64'(ndone), 64'd1);

        // Reset asserted in cycle N+4 of a write over zeroed bytes
        @(negedge clk);
        start = 1'b1; icode = 4'h4; valE = 64'h20; valA = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valM", valM, 64'd0);
        check("mem_0x22", 64'(dut.u_ram.mem[34]), 64'hFF);
        check("mem_0x23", 64'(dut.u_ram.mem[35]), 64'h00);
        run_op(4'h5, 64'h20, 64'd0, 64'd0, lat);
        check("after_rst_latency", 64'(lat), 64'd9);
        check("after_rst_valM", valM, 64'h0000_0000_00FF_FFFF);

        // Randomized traffic, including held start and occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            icode = 4'($urandom_range(0, 15));
            valE  = rand_addr();
            valA  = ($urandom_range(0, 1) == 0) ? rand_addr() : rand64();
            valP  = rand64();
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (12) @(negedge clk);

        bad = 0;
        for (int i = 0; i < MEM; i++) begin
            if (dut.u_ram.mem[i] !== mmem[i]) bad++;
        end
        check("final_memory_mismatch_count", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
